// File: rtl/hazard_ctrl_unit.sv
// Stall/flush sequencer for the 5-stage core: load-use bubbles, redirect flushes,
// data-memory wait freezes and saturating performance counters.
module hazard_ctrl_unit #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic             uses_rs1_ID,
  input  logic             uses_rs2_ID,
  input  logic [4:0]       rd_EX,
  input  logic             MemRead_EX,
  input  logic             pc_redirect_EX,
  input  logic             mem_req_MEM,
  input  logic             mem_ready,
  input  logic             count_clear,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             mem_wb_bubble,
  output logic [1:0]       ctrl_state,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] lu_cnt
);

  localparam logic [1:0]  ST_RUN       = 2'd0;
  localparam logic [1:0]  ST_FLUSH     = 2'd1;
  localparam logic [1:0]  ST_MEM_WAIT  = 2'd2;
  localparam logic [3:0]  FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_VAL  = 16'(MEM_TIMEOUT);

  logic [1:0]       state_q, state_d;
  logic [3:0]       flush_left_q, flush_left_d;
  logic [15:0]      wait_cnt_q, wait_cnt_d;
  logic             from_flush_q, from_flush_d;
  logic             mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;

  logic       load_use, mem_stall, freeze, inc_flush, inc_lu;
  logic [1:0] decode_state;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  always_comb begin
    load_use  = MemRead_EX && (rd_EX != 5'd0) &&
                ((uses_rs1_ID && (rs1_ID == rd_EX)) || (uses_rs2_ID && (rs2_ID == rd_EX)));
    mem_stall = mem_req_MEM && !mem_ready;
    // Once waiting, only mem_ready releases the freeze; MEM is held so its request persists.
    freeze       = (state_q == ST_MEM_WAIT) ? !mem_ready : mem_stall;
    decode_state = (state_q == ST_MEM_WAIT) ? (from_flush_q ? ST_FLUSH : ST_RUN) : state_q;

    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_en      = 1'b1;
    id_ex_flush   = 1'b0;
    ex_mem_en     = 1'b1;
    mem_wb_bubble = 1'b0;
    state_d       = state_q;
    flush_left_d  = flush_left_q;
    wait_cnt_d    = wait_cnt_q;
    from_flush_d  = from_flush_q;
    inc_flush     = 1'b0;
    inc_lu        = 1'b0;

    if (!rst) begin
      if (freeze) begin
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        id_ex_en      = 1'b0;
        ex_mem_en     = 1'b0;
        mem_wb_bubble = 1'b1;
        state_d       = ST_MEM_WAIT;
        if (state_q != ST_MEM_WAIT) from_flush_d = (state_q == ST_FLUSH);
        wait_cnt_d = (wait_cnt_q == 16'hFFFF) ? wait_cnt_q : wait_cnt_q + 16'd1;
      end else begin
        wait_cnt_d = 16'd0;
        if (decode_state == ST_FLUSH) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          if (pc_redirect_EX) begin
            inc_flush    = 1'b1;
            flush_left_d = FLUSH_RELOAD;
            state_d      = ST_FLUSH;
          end else if (flush_left_q <= 4'd1) begin
            flush_left_d = 4'd0;
            state_d      = ST_RUN;
          end else begin
            flush_left_d = flush_left_q - 4'd1;
            state_d      = ST_FLUSH;
          end
        end else begin
          state_d = ST_RUN;
          if (pc_redirect_EX) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            inc_flush   = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_d      = ST_FLUSH;
              flush_left_d = FLUSH_RELOAD;
            end
          end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
            inc_lu      = 1'b1;
          end
        end
      end
    end

    mem_timeout_d = mem_timeout_q || (freeze && !rst && (wait_cnt_d == TIMEOUT_VAL));
    stall_cnt_d   = pc_en     ? stall_cnt_q : sat_inc(stall_cnt_q);
    flush_cnt_d   = inc_flush ? sat_inc(flush_cnt_q) : flush_cnt_q;
    lu_cnt_d      = inc_lu    ? sat_inc(lu_cnt_q) : lu_cnt_q;
    if (count_clear) begin
      mem_timeout_d = 1'b0;
      stall_cnt_d   = '0;
      flush_cnt_d   = '0;
      lu_cnt_d      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      flush_left_q  <= 4'd0;
      wait_cnt_q    <= 16'd0;
      from_flush_q  <= 1'b0;
      mem_timeout_q <= 1'b0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
      lu_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      flush_left_q  <= flush_left_d;
      wait_cnt_q    <= wait_cnt_d;
      from_flush_q  <= from_flush_d;
      mem_timeout_q <= mem_timeout_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
      lu_cnt_q      <= lu_cnt_d;
    end
  end

  assign ctrl_state  = state_q;
  assign mem_timeout = mem_timeout_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;
  assign lu_cnt      = lu_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed scoreboard bench for hazard_ctrl_unit with FLUSH_CYCLES=3, MEM_TIMEOUT=8, CNT_W=4.
module tb_hazard_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1_ID, rs2_ID, rd_EX;
  logic       uses_rs1_ID, uses_rs2_ID, MemRead_EX, pc_redirect_EX;
  logic       mem_req_MEM, mem_ready, count_clear;
  logic       pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_bubble;
  logic [1:0] ctrl_state;
  logic       mem_timeout;
  logic [3:0] stall_cnt, flush_cnt, lu_cnt;

  int total = 0;
  int bad   = 0;

  logic [8:0] exp_q[$];
  string      tag_q[$];

  // Output vector order: pc_en,if_id_en,if_id_flush,id_ex_en,id_ex_flush,ex_mem_en,mem_wb_bubble
  localparam logic [6:0] C_DEF = 7'b1101010;
  localparam logic [6:0] C_FRZ = 7'b0000001;
  localparam logic [6:0] C_RED = 7'b1111110;
  localparam logic [6:0] C_LU  = 7'b0001110;

  hazard_ctrl_unit #(.FLUSH_CYCLES(3), .MEM_TIMEOUT(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .uses_rs1_ID(uses_rs1_ID), .uses_rs2_ID(uses_rs2_ID),
    .rd_EX(rd_EX), .MemRead_EX(MemRead_EX), .pc_redirect_EX(pc_redirect_EX),
    .mem_req_MEM(mem_req_MEM), .mem_ready(mem_ready), .count_clear(count_clear),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush), .id_ex_en(id_ex_en),
    .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en), .mem_wb_bubble(mem_wb_bubble),
    .ctrl_state(ctrl_state), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .lu_cnt(lu_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic apply_stimulus(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                                input logic u2, input logic [4:0] rd, input logic mr,
                                input logic redir, input logic req, input logic rdy);
    rs1_ID = rs1; uses_rs1_ID = u1; rs2_ID = rs2; uses_rs2_ID = u2;
    rd_EX = rd; MemRead_EX = mr; pc_redirect_EX = redir; mem_req_MEM = req; mem_ready = rdy;
  endtask

  task automatic idle();
    apply_stimulus(5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Push expectation for this cycle, compare on the falling edge, then advance past the rising edge.
  task automatic step(input string tag, input logic [6:0] ec, input logic [1:0] es);
    logic [8:0] e;
    string      t;
    exp_q.push_back({ec, es});
    tag_q.push_back(tag);
    @(negedge clk);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check_output(t, {7'd0, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
                 mem_wb_bubble, ctrl_state}, {7'd0, e});
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input string tag, input logic [3:0] s, input logic [3:0] f,
                           input logic [3:0] l, input logic t);
    check_output({tag, "_stall"}, {12'd0, stall_cnt}, {12'd0, s});
    check_output({tag, "_flush"}, {12'd0, flush_cnt}, {12'd0, f});
    check_output({tag, "_lu"},    {12'd0, lu_cnt},    {12'd0, l});
    check_output({tag, "_tmo"},   {15'd0, mem_timeout}, {15'd0, t});
  endtask

  initial begin
    rst = 1'b1;
    count_clear = 1'b0;
    idle();
    @(posedge clk);
    #1;
    pc_redirect_EX = 1'b1;
    step("rst_forced_default", C_DEF, 2'd0);
    rst = 1'b0;
    idle();
    step("post_rst_idle", C_DEF, 2'd0);
    check_cnt("after_rst", 4'd0, 4'd0, 4'd0, 1'b0);

    apply_stimulus(5'd3, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    step("lu_rs2", C_LU, 2'd0);
    idle();
    step("lu_release", C_DEF, 2'd0);
    apply_stimulus(5'd0, 1'b1, 5'd4, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("lu_rd0", C_DEF, 2'd0);
    apply_stimulus(5'd7, 1'b0, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    step("lu_unused_rs1", C_DEF, 2'd0);
    apply_stimulus(5'd7, 1'b1, 5'd3, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    step("lu_not_load", C_DEF, 2'd0);
    check_cnt("lu_once", 4'd1, 4'd0, 4'd1, 1'b0);

    idle();
    pc_redirect_EX = 1'b1;
    step("redir_run", C_RED, 2'd0);
    apply_stimulus(5'd3, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    step("flush1_lu_ignored", C_RED, 2'd1);
    idle();
    step("flush2", C_RED, 2'd1);
    step("flush_done", C_DEF, 2'd0);
    check_cnt("redir_once", 4'd1, 4'd1, 4'd1, 1'b0);

    pc_redirect_EX = 1'b1;
    step("reload_a", C_RED, 2'd0);
    pc_redirect_EX = 1'b0;
    step("reload_b", C_RED, 2'd1);
    pc_redirect_EX = 1'b1;
    step("reload_redir", C_RED, 2'd1);
    pc_redirect_EX = 1'b0;
    step("reload_c", C_RED, 2'd1);
    step("reload_d", C_RED, 2'd1);
    step("reload_done", C_DEF, 2'd0);
    check_cnt("reload", 4'd1, 4'd3, 4'd1, 1'b0);

    count_clear = 1'b1;
    step("clear", C_DEF, 2'd0);
    count_clear = 1'b0;
    check_cnt("cleared", 4'd0, 4'd0, 4'd0, 1'b0);

    apply_stimulus(5'd3, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    step("wait_enter", C_FRZ, 2'd0);
    for (int i = 0; i < 3; i++) step("wait_hold", C_FRZ, 2'd2);
    mem_ready = 1'b1;
    step("wait_release_redir", C_RED, 2'd2);
    idle();
    step("wait_flush1", C_RED, 2'd1);
    step("wait_flush2", C_RED, 2'd1);
    step("wait_back_run", C_DEF, 2'd0);
    check_cnt("wait4", 4'd4, 4'd1, 4'd0, 1'b0);

    pc_redirect_EX = 1'b1;
    step("fw_redir", C_RED, 2'd0);
    apply_stimulus(5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0);
    step("fw_freeze", C_FRZ, 2'd1);
    step("fw_hold", C_FRZ, 2'd2);
    mem_ready = 1'b1;
    step("fw_release", C_RED, 2'd2);
    idle();
    step("fw_flush_last", C_RED, 2'd1);
    step("fw_run", C_DEF, 2'd0);
    check_cnt("flush_wait", 4'd6, 4'd2, 4'd0, 1'b0);

    count_clear = 1'b1;
    step("clear2", C_DEF, 2'd0);
    count_clear = 1'b0;
    apply_stimulus(5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0);
    step("tmo_enter", C_FRZ, 2'd0);
    for (int i = 0; i < 6; i++) step("tmo_hold", C_FRZ, 2'd2);
    check_cnt("tmo_7", 4'd7, 4'd0, 4'd0, 1'b0);
    step("tmo_8th", C_FRZ, 2'd2);
    check_cnt("tmo_8", 4'd8, 4'd0, 4'd0, 1'b1);
    step("tmo_stay", C_FRZ, 2'd2);
    step("tmo_stay2", C_FRZ, 2'd2);
    check_cnt("tmo_sticky", 4'd10, 4'd0, 4'd0, 1'b1);
    rst = 1'b1;
    step("tmo_rst_forced", C_DEF, 2'd2);
    rst = 1'b0;
    idle();
    step("tmo_after_rst", C_DEF, 2'd0);
    check_cnt("tmo_reset", 4'd0, 4'd0, 4'd0, 1'b0);

    apply_stimulus(5'd5, 1'b1, 5'd2, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step("lu_sat_loop", C_LU, 2'd0);
    check_cnt("lu_sat", 4'd15, 4'd0, 4'd15, 1'b0);
    count_clear = 1'b1;
    step("lu_clear_same", C_LU, 2'd0);
    count_clear = 1'b0;
    check_cnt("lu_cleared", 4'd0, 4'd0, 4'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
